// File: rtl/q_align_sequencer_pkg.sv
//------------------------------------------------------------------------------
// q_align_sequencer_pkg
// Shared types and helpers for the fixed-point alignment sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package q_align_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } q_seq_state_e;

  localparam int SAT_CNT_W_DFLT = 16;

  typedef logic [SAT_CNT_W_DFLT-1:0] q_sat_cnt_t;

  // Total bit width of a signed Q(i,f) value; the sign bit is counted in i.
  function automatic int q_width(input int i_bits, input int f_bits);
    return i_bits + f_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/q_align_lane.sv
//------------------------------------------------------------------------------
// q_align_lane
// Combinational Q(IN_I,IN_F) -> Q(OUT_I,OUT_F) integer-bit alignment lane.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module q_align_lane
  import q_align_sequencer_pkg::*;
#(
  parameter int IN_I  = 8,
  parameter int IN_F  = 8,
  parameter int OUT_I = 4,
  parameter int OUT_F = 8,
  localparam int W_IN  = q_width(IN_I, IN_F),
  localparam int W_OUT = q_width(OUT_I, OUT_F)
) (
  input  logic [W_IN-1:0]  in_val,
  output logic [W_OUT-1:0] out_val,
  output logic             sat
);

  if (IN_I == OUT_I) begin : g_pass
    assign out_val = in_val;
    assign sat     = 1'b0;
  end else if (IN_I < OUT_I) begin : g_sext
    assign out_val = {{(W_OUT-W_IN){in_val[W_IN-1]}}, in_val};
    assign sat     = 1'b0;
  end else begin : g_clamp
    localparam int DROP = W_IN - W_OUT;

    logic [DROP:0] top_bits;
    logic          overflow;

    // Value fits only if every dropped bit matches the new sign bit.
    assign top_bits = in_val[W_IN-1 -: DROP+1];
    assign overflow = !((&top_bits) || (~|top_bits));
    assign sat      = overflow;
    assign out_val  = !overflow       ? in_val[W_OUT-1:0] :
                      in_val[W_IN-1]  ? {1'b1, {(W_OUT-1){1'b0}}} :
                                        {1'b0, {(W_OUT-1){1'b1}}};
  end

endmodule

`default_nettype wire

// File: rtl/q_align_sequencer.sv
//------------------------------------------------------------------------------
// q_align_sequencer
// Buffers a vector, streams it LANES elements per beat through alignment lanes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module q_align_sequencer
  import q_align_sequencer_pkg::*;
#(
  parameter int IN_I      = 8,
  parameter int IN_F      = 8,
  parameter int OUT_I     = 4,
  parameter int OUT_F     = 8,
  parameter int VEC_LEN   = 64,
  parameter int LANES     = 8,
  parameter int SAT_CNT_W = $bits(q_sat_cnt_t),
  localparam int W_IN     = q_width(IN_I, IN_F),
  localparam int W_OUT    = q_width(OUT_I, OUT_F),
  localparam int BEATS    = VEC_LEN / LANES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [VEC_LEN*W_IN-1:0]  in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*W_OUT-1:0]   out_data,
  output logic                     out_last,
  output logic [LANES-1:0]         out_sat,
  input  logic                     clear_stats,
  output logic [SAT_CNT_W-1:0]     sat_count,
  output logic                     busy
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int POP_W  = $clog2(LANES + 1);

  if (OUT_F != IN_F) begin : g_frac_check
    $error("q_align_sequencer: OUT_F must equal IN_F");
  end
  if ((VEC_LEN % LANES) != 0) begin : g_len_check
    $error("q_align_sequencer: VEC_LEN must be a multiple of LANES");
  end

  q_seq_state_e             state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [VEC_LEN*W_IN-1:0]  vec_q, vec_d;
  logic [SAT_CNT_W-1:0]     sat_count_q, sat_count_d;

  logic                     accept;
  logic                     load;
  logic [LANES*W_IN-1:0]    beat_slice;
  logic [POP_W-1:0]         sat_pop;
  logic [SAT_CNT_W:0]       sat_sum;

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign out_last  = (beat_q == BEAT_W'(BEATS - 1));
  assign sat_count = sat_count_q;

  assign accept    = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (accept && out_last);
  assign load      = in_valid && in_ready;

  assign beat_slice = vec_q[int'(beat_q)*LANES*W_IN +: LANES*W_IN];

  for (genvar j = 0; j < LANES; j++) begin : g_lanes
    q_align_lane #(
      .IN_I  (IN_I),
      .IN_F  (IN_F),
      .OUT_I (OUT_I),
      .OUT_F (OUT_F)
    ) u_lane (
      .in_val  (beat_slice[j*W_IN +: W_IN]),
      .out_val (out_data[j*W_OUT +: W_OUT]),
      .sat     (out_sat[j])
    );
  end

  always_comb begin
    sat_pop = '0;
    for (int j = 0; j < LANES; j++) begin
      sat_pop = sat_pop + POP_W'(out_sat[j]);
    end
  end

  assign sat_sum = {1'b0, sat_count_q} + (SAT_CNT_W+1)'(sat_pop);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    vec_d       = vec_q;
    sat_count_d = sat_count_q;

    // A new vector may land on the same edge the previous last beat leaves.
    if (load) begin
      vec_d   = in_vec;
      beat_d  = '0;
      state_d = RUN;
    end else if (accept) begin
      if (out_last) begin
        beat_d  = '0;
        state_d = IDLE;
      end else begin
        beat_d  = beat_q + BEAT_W'(1);
      end
    end

    if (clear_stats) begin
      sat_count_d = '0;
    end else if (accept) begin
      sat_count_d = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      vec_q       <= '0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      vec_q       <= vec_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_q_align_sequencer.sv
//------------------------------------------------------------------------------
// tb_q_align_sequencer
// Directed scoreboard bench for q_align_sequencer at default parameters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_q_align_sequencer;

  localparam int W_IN    = 16;
  localparam int W_OUT   = 12;
  localparam int LANES   = 8;
  localparam int VEC_LEN = 64;
  localparam int BEATS   = 8;
  localparam int CNT_W   = 16;

  typedef logic [VEC_LEN*W_IN-1:0] vec_t;
  typedef struct {
    logic [LANES*W_OUT-1:0] d;
    logic [LANES-1:0]       s;
    logic                   last;
  } beat_t;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  vec_t                   in_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*W_OUT-1:0] out_data;
  logic                   out_last;
  logic [LANES-1:0]       out_sat;
  logic                   clear_stats;
  logic [CNT_W-1:0]       sat_count;
  logic                   busy;

  int n_vec = 0;
  int n_bad = 0;

  beat_t            exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  q_align_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_sat     (out_sat),
    .clear_stats (clear_stats),
    .sat_count   (sat_count),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t fill(input logic [W_IN-1:0] x);
    vec_t v;
    for (int e = 0; e < VEC_LEN; e++) v[e*W_IN +: W_IN] = x;
    return v;
  endfunction

  // Reference alignment: clamp a signed Q8.8 value into the Q4.8 range.
  function automatic beat_t model_beat(input vec_t v, input int b);
    beat_t r;
    logic signed [W_IN-1:0] e;
    int x;
    r.d = '0;
    r.s = '0;
    r.last = (b == BEATS - 1);
    for (int j = 0; j < LANES; j++) begin
      e = v[(b*LANES + j)*W_IN +: W_IN];
      x = e;
      if (x > 2047) begin
        r.d[j*W_OUT +: W_OUT] = 12'h7FF;
        r.s[j] = 1'b1;
      end else if (x < -2048) begin
        r.d[j*W_OUT +: W_OUT] = 12'h800;
        r.s[j] = 1'b1;
      end else begin
        r.d[j*W_OUT +: W_OUT] = e[W_OUT-1:0];
      end
    end
    return r;
  endfunction

  always @(negedge clock) begin
    beat_t f;
    logic  exp_ready;
    int    pop;
    if (reset) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      pop = -1;
      exp_ready = (exp_q.size() == 0) ? 1'b1 : (out_ready && exp_q[0].last);
      chk("sb_valid", out_valid, exp_q.size() != 0);
      chk("sb_busy", busy, exp_q.size() != 0);
      chk("sb_in_ready", in_ready, exp_ready);
      chk("sb_count", sat_count, exp_cnt);
      if (exp_q.size() != 0) begin
        f = exp_q[0];
        chk("sb_data", out_data, f.d);
        chk("sb_sat", out_sat, f.s);
        chk("sb_last", out_last, f.last);
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop = $countones(f.s);
        end
      end
      if (clear_stats) exp_cnt = '0;
      else if (pop >= 0) exp_cnt = (int'(exp_cnt) + pop > 65535) ? 16'hFFFF : exp_cnt + 16'(pop);
      if (in_valid && exp_ready)
        for (int b = 0; b < BEATS; b++) exp_q.push_back(model_beat(in_vec, b));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    in_vec   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("send_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle);
    int n = 0;
    while (busy && n < 200) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t v;
    int   n_acc;
    int   guard;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_vec      = '0;
    out_ready   = 1'b1;
    clear_stats = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_sat", out_sat, 8'h00);
    chk("rst_data", out_data, 96'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", sat_count, 16'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // All elements 3.25: straight pass-through, last only on beat 7.
    send(fill(16'h0340));
    for (int k = 0; k < BEATS; k++) begin
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_data", out_data, {8{12'h340}});
      chk("t1_last", out_last, k == BEATS - 1);
      tick();
    end
    chk("t1_idle", out_valid, 1'b0);
    chk("t1_count", sat_count, 16'd0);

    // +100.0 at element 0 and -100.0 at element 9.
    v = '0;
    v[0*W_IN +: W_IN] = 16'h6400;
    v[9*W_IN +: W_IN] = 16'h9C00;
    send(v);
    chk("t2_lane0", out_data[11:0], 12'h7FF);
    chk("t2_sat0", out_sat, 8'h01);
    tick();
    chk("t2_lane1", out_data[23:12], 12'h800);
    chk("t2_sat1", out_sat, 8'h02);
    wait_idle(1'b0);
    chk("t2_count", sat_count, 16'd2);

    // Back-to-back: second vector loads on the first vector's last beat.
    in_vec   = fill(16'h0100);
    in_valid = 1'b1;
    tick();
    for (int e = 0; e < VEC_LEN; e++) v[e*W_IN +: W_IN] = 16'((e - 32) * 32);
    in_vec = v;
    for (int c = 0; c < 2*BEATS; c++) begin
      chk("b2b_valid", out_valid, 1'b1);
      if (c == 3) chk("b2b_ready_low", in_ready, 1'b0);
      if (c == BEATS - 1) chk("b2b_ready_pulse", in_ready, 1'b1);
      tick();
      if (c == BEATS - 1) in_valid = 1'b0;
    end
    chk("b2b_done", out_valid, 1'b0);

    // Range edges under a toggling out_ready: 8.0, -8.0-lsb and -128 clamp.
    v = fill(16'h0080);
    v[2*W_IN  +: W_IN] = 16'h0800;
    v[3*W_IN  +: W_IN] = 16'h07FF;
    v[17*W_IN +: W_IN] = 16'hF7FF;
    v[18*W_IN +: W_IN] = 16'hF800;
    v[40*W_IN +: W_IN] = 16'h8000;
    send(v);
    wait_idle(1'b1);
    chk("t4_count", sat_count, 16'd5);

    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr_count", sat_count, 16'd0);

    // Drive the counter to 2^16-2 with fully saturating vectors.
    in_vec   = fill(16'h6400);
    in_valid = 1'b1;
    n_acc    = 0;
    guard    = 0;
    while (n_acc < 1023 && guard < 10000) begin
      if (in_ready) n_acc++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("preload_timeout", n_acc, 1023);
    wait_idle(1'b0);
    chk("preload_a", sat_count, 16'hFFC0);
    v = '0;
    for (int e = 0; e < 62; e++) v[e*W_IN +: W_IN] = 16'h6400;
    send(v);
    wait_idle(1'b0);
    chk("preload_b", sat_count, 16'hFFFE);

    v = '0;
    for (int e = 0; e < 4; e++) v[e*W_IN +: W_IN] = 16'h6400;
    for (int e = 8; e < 16; e++) v[e*W_IN +: W_IN] = 16'h9C00;
    send(v);
    tick();
    chk("sticky_a", sat_count, 16'hFFFF);
    wait_idle(1'b0);
    chk("sticky_b", sat_count, 16'hFFFF);

    // Clear coinciding with a saturating beat drops that beat's count.
    v = '0;
    for (int e = 0; e < LANES; e++) v[e*W_IN +: W_IN] = 16'h6400;
    send(v);
    chk("clr_beat_sat", out_sat, 8'hFF);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr_win", sat_count, 16'd0);
    wait_idle(1'b0);
    chk("clr_after", sat_count, 16'd0);

    // Reset while beat 3 is presented.
    send(fill(16'h6400));
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_count", sat_count, 16'd0);
    chk("mid_rst_data", out_data, 96'h0);
    send(fill(16'hFF80));
    chk("restart_data", out_data, {8{12'hF80}});
    chk("restart_last", out_last, 1'b0);
    wait_idle(1'b0);
    chk("restart_count", sat_count, 16'd0);
    chk("restart_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
